seq_divider_nb: RTL and testbench

- Iterative unsigned restoring divider that produces one quotient bit per clock.
- It is the inverse companion of the array multiplier.
- Used to undo or check products and to serve datapath divisions where area matters more than latency.
- A start/busy/done handshake lets a controller FSM issue one division at a time.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 45 ++++
 rtl/seq_divider_nb.sv | 143 ++++++++++++++
 tb/tb_seq_divider_nb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   - state_e       : FSM state encoding (IDLE / RUN / DONE)
//   - MAX_N         : widest operand width the helpers below support
//   - div0_quotient : all-ones quotient returned for a divide by zero
`timescale 1ns/1ps
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int MAX_N = 128;

    // All-ones quotient of width n, right-aligned in a MAX_N-bit word
    function automatic logic [MAX_N-1:0] div0_quotient(input int n);
        return {MAX_N{1'b1}} >> (MAX_N - n);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   p_i     : partial remainder before the step (n+1 bits)
//   d_bit_i : next dividend bit shifted into the remainder
//   b_i     : divisor
//   p_o     : partial remainder after the step
//   q_bit_o : quotient bit produced by this step
`timescale 1ns/1ps
module div_step #(
    parameter int n = 32
) (
    input  logic [n:0]   p_i,
    input  logic         d_bit_i,
    input  logic [n-1:0] b_i,
    output logic [n:0]   p_o,
    output logic         q_bit_o
);
    import div_pkg::*;

    logic [n:0] p_shift_s;
    logic [n:0] b_ext_s;
    logic [n:0] p_sub_s;
    // The remainder is always below the divisor, so its top bit is zero
    // between steps and is dropped by the shift.
    logic       unused_p_msb_s;

    assign unused_p_msb_s = p_i[n];
    assign p_shift_s      = {p_i[n-1:0], d_bit_i};
    assign b_ext_s        = {1'b0, b_i};
    assign p_sub_s        = p_shift_s - b_ext_s;

    // Subtract when the shifted remainder covers the divisor, otherwise restore
    always_comb begin
        p_o     = p_shift_s;
        q_bit_o = 1'b0;
        if (p_shift_s >= b_ext_s) begin
            p_o     = p_sub_s;
            q_bit_o = 1'b1;
        end else begin
            p_o     = p_shift_s;
            q_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider_nb.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : request, accepted in IDLE or DONE
//   A, B     : dividend / divisor, sampled on the accepting edge
//   Q, R     : registered quotient / remainder
//   busy     : high while iterating
//   done     : one-cycle pulse when Q/R update
//   div_zero : set with done when B was zero, held until next start
`timescale 1ns/1ps
module seq_divider_nb #(
    parameter int n  = 32,
    parameter int CW = $clog2(n) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n-1:0] Q,
    output logic [n-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);
    import div_pkg::*;

    localparam logic [MAX_N-1:0] DIV0_Q_WIDE = div0_quotient(n);
    localparam logic [n-1:0]     DIV0_Q      = DIV0_Q_WIDE[n-1:0];
    localparam logic [CW-1:0]    CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LOAD    = CW'(n);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  dvd_q, dvd_d;   // dividend in, quotient bits shifted in at LSB
    logic [n-1:0]  dvs_q, dvs_d;
    logic [n:0]    p_q, p_d;
    logic [n-1:0]  q_q, q_d;
    logic [n-1:0]  r_q, r_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;

    logic [n:0]    p_step_s;
    logic          q_bit_s;

    div_step #(.n(n)) u_step (
        .p_i     (p_q),
        .d_bit_i (dvd_q[n-1]),
        .b_i     (dvs_q),
        .p_o     (p_step_s),
        .q_bit_o (q_bit_s)
    );

    // Next-state, datapath and output-register computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvd_d = A;
                    dvs_d = B;
                    p_d   = {(n+1){1'b0}};
                    if (B == {n{1'b0}}) begin
                        // Divide by zero resolves on the accepting edge
                        state_d = S_DONE;
                        cnt_d   = {CW{1'b0}};
                        q_d     = DIV0_Q;
                        r_d     = A;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CNT_LOAD;
                        dz_d    = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                p_d   = p_step_s;
                dvd_d = {dvd_q[n-2:0], q_bit_s};
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                    q_d     = {dvd_q[n-2:0], q_bit_s};
                    r_d     = p_step_s[n-1:0];
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            dvd_q   <= {n{1'b0}};
            dvs_q   <= {n{1'b0}};
            p_q     <= {(n+1){1'b0}};
            q_q     <= {n{1'b0}};
            r_q     <= {n{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign Q        = q_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider_nb.sv
`timescale 1ns/1ps
module tb_seq_divider_nb;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic [31:0] q, r;
    logic        busy, done, dz;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [7:0]  q8, r8;
    logic        busy8, done8, dz8;

    always #5 clk = ~clk;

    seq_divider_nb #(.n(32)) dut (
        .clk(clk), .reset(reset), .start(start), .A(a), .B(b),
        .Q(q), .R(r), .busy(busy), .done(done), .div_zero(dz)
    );

    seq_divider_nb #(.n(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8),
        .Q(q8), .R(r8), .busy(busy8), .done(done8), .div_zero(dz8)
    );

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic exp_t model(input logic [31:0] ai, input logic [31:0] bi);
        exp_t e;
        if (bi == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = ai; e.dz = 1'b1;
        end else begin
            e.q = ai / bi; e.r = ai % bi; e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e = '0;
        e.q = 32'hDEAD_BEEF;
        if (sb.size() > 0) e = sb.pop_front();
        return e;
    endfunction

    // Called at a negedge; issues a start, scrambles A/B afterwards and waits for done.
    task automatic drive_div(input logic [31:0] ai, input logic [31:0] bi,
                             output int edges, output int busy_cyc,
                             output bit first_busy, output bit timeout);
        sb.push_back(model(ai, bi));
        start = 1'b1; a = ai; b = bi;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        first_busy = busy;
        busy_cyc = 0;
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        timeout = (done !== 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        #12;
        n_total++;
        if ({q, r, busy, done, dz} !== 67'd0) $display("FAIL reset_state: got Q=%0h R=%0h busy=%b done=%b dz=%b want all 0", q, r, busy, done, dz);
        else n_pass++;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({q, r, busy, done, dz} !== 67'd0) $display("FAIL reset_release: got Q=%0h R=%0h busy=%b done=%b dz=%b want all 0", q, r, busy, done, dz);
        else n_pass++;
    endtask

    task automatic test_basic();
        int edges, bc; bit fb, to; exp_t e;
        drive_div(32'd100, 32'd7, edges, bc, fb, to);
        e = pop_exp();
        n_total++;
        if (to) $display("FAIL basic_timeout: done not seen after %0d edges", edges);
        else n_pass++;
        n_total++;
        if (edges !== 33) $display("FAIL basic_latency: got %0d edges want 33", edges);
        else n_pass++;
        n_total++;
        if (bc !== 32) $display("FAIL basic_busy_cycles: got %0d want 32", bc);
        else n_pass++;
        n_total++;
        if (q !== e.q || q !== 32'd14) $display("FAIL basic_q: got %0d want %0d", q, e.q);
        else n_pass++;
        n_total++;
        if (r !== e.r || r !== 32'd2) $display("FAIL basic_r: got %0d want %0d", r, e.r);
        else n_pass++;
        n_total++;
        if (dz !== e.dz) $display("FAIL basic_dz: got %b want %b", dz, e.dz);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || q !== 32'd14 || busy !== 1'b0) $display("FAIL basic_done_pulse: got done=%b busy=%b Q=%0d want done=0 busy=0 Q=14", done, busy, q);
        else n_pass++;
    endtask

    task automatic test_extremes();
        int edges, bc; bit fb, to; exp_t e;
        logic [31:0] av [2];
        logic [31:0] bv [2];
        av[0] = 32'hFFFF_FFFF; bv[0] = 32'd1;
        av[1] = 32'd5;         bv[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            drive_div(av[i], bv[i], edges, bc, fb, to);
            e = pop_exp();
            n_total++;
            if (to || q !== e.q || r !== e.r || dz !== 1'b0)
                $display("FAIL extreme_%0d: got Q=%0h R=%0h dz=%b want Q=%0h R=%0h dz=0", i, q, r, dz, e.q, e.r);
            else n_pass++;
        end
    endtask

    task automatic test_div_zero();
        int edges, bc; bit fb, to; exp_t e;
        drive_div(32'd1234, 32'd0, edges, bc, fb, to);
        e = pop_exp();
        n_total++;
        if (to || edges !== 1) $display("FAIL dz_latency: got %0d edges want 1", edges);
        else n_pass++;
        n_total++;
        if (q !== e.q || r !== e.r || dz !== 1'b1 || fb !== 1'b0)
            $display("FAIL dz_result: got Q=%0h R=%0d dz=%b busy=%b want Q=%0h R=%0d dz=1 busy=0", q, r, dz, fb, e.q, e.r);
        else n_pass++;
        // back-to-back start from the DONE cycle
        drive_div(32'd9, 32'd3, edges, bc, fb, to);
        e = pop_exp();
        n_total++;
        if (to || q !== e.q || r !== e.r || dz !== 1'b0)
            $display("FAIL dz_clear: got Q=%0d R=%0d dz=%b want Q=%0d R=%0d dz=0", q, r, dz, e.q, e.r);
        else n_pass++;
    endtask

    task automatic test_mid_run_start();
        int edges, bc; bit fb, to; exp_t e;
        sb.push_back(model(32'd1000, 32'd3));
        start = 1'b1; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; a = 32'd77; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        e = pop_exp();
        n_total++;
        if (done !== 1'b1 || q !== e.q || r !== e.r)
            $display("FAIL mid_run_start: got done=%b Q=%0d R=%0d want Q=%0d R=%0d", done, q, r, e.q, e.r);
        else n_pass++;
        // start held during DONE launches immediately
        drive_div(32'd50000, 32'd123, edges, bc, fb, to);
        e = pop_exp();
        n_total++;
        if (fb !== 1'b1) $display("FAIL b2b_busy: got busy=%b want 1", fb);
        else n_pass++;
        n_total++;
        if (to || edges !== 33 || q !== e.q || r !== e.r)
            $display("FAIL b2b_result: got edges=%0d Q=%0d R=%0d want edges=33 Q=%0d R=%0d", edges, q, r, e.q, e.r);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        bit bad;
        start = 1'b1; a = 32'd1000; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({q, r, busy, done, dz} !== 67'd0)
            $display("FAIL async_reset: got Q=%0d R=%0d busy=%b done=%b dz=%b want all 0", q, r, busy, done, dz);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || q !== 32'd0) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL post_reset_idle: got busy=%b done=%b Q=%0d want 0 0 0", busy, done, q);
        else n_pass++;
    endtask

    task automatic test_random8();
        exp_t e;
        logic [15:0] recon;
        int edges;
        for (int i = 0; i < 2000; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(1, 255));
            sb.push_back(model({24'd0, a8}, {24'd0, b8}));
            recon = 16'd0;
            start8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start8 = 1'b0;
            edges = 1;
            while (done8 !== 1'b1 && edges < 30) begin
                @(negedge clk);
                edges++;
            end
            e = pop_exp();
            recon = 16'(q8) * 16'(e.q[7:0] == q8 ? b8 : b8) + 16'(r8);
            n_total++;
            if (done8 !== 1'b1 || edges !== 9 || recon !== {8'd0, e.q[7:0] * 8'd0 + 8'd0} + 16'(e.q) * 16'(b8) + 16'(e.r)
                || r8 >= b8 || q8 !== e.q[7:0] || r8 !== e.r[7:0])
                $display("FAIL rand8_%0d: got Q=%0d R=%0d edges=%0d want Q=%0d R=%0d edges=9", i, q8, r8, edges, e.q, e.r);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_mid_run_start();
        test_reset_mid_run();
        test_random8();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
